// File: rtl/sd_ser_pkg.sv
// Shared types for the sd message-to-beat serializer.
package sd_ser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sd_ser_state_e;

endpackage

// File: rtl/sd_msg_serializer_if.sv
// Message-in / beat-out handshake bundle for sd_msg_serializer.
interface sd_msg_serializer_if #(
  parameter int BEAT_W    = 8,
  parameter int NUM_BEATS = 4
);
  localparam int LEN_W = $clog2(NUM_BEATS);

  logic                        s_valid;
  logic [NUM_BEATS*BEAT_W-1:0] s_data;
  logic [LEN_W-1:0]            s_len;
  logic                        s_ready;
  logic                        d_valid;
  logic [BEAT_W-1:0]           d_data;
  logic                        d_last;
  logic                        d_ready;
  logic                        busy;

  // master: the surrounding logic that supplies messages and consumes beats
  modport master (
    output s_valid, s_data, s_len, d_ready,
    input  s_ready, d_valid, d_data, d_last, busy
  );

  modport slave (
    input  s_valid, s_data, s_len, d_ready,
    output s_ready, d_valid, d_data, d_last, busy
  );
endinterface

// File: rtl/sd_msg_serializer.sv
// Splits one wide message per handshake into LSB-first valid/ready beats,
// with d_last on the final beat and zero-bubble message back-to-back.
module sd_msg_serializer
  import sd_ser_pkg::*;
#(
  parameter int BEAT_W    = 8,
  parameter int NUM_BEATS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  sd_msg_serializer_if.slave  bus
);
  localparam int LEN_W = $clog2(NUM_BEATS);
  localparam int MSG_W = NUM_BEATS * BEAT_W;

  sd_ser_state_e    state_q, state_d;
  logic             d_valid_q, d_valid_d;
  logic             d_last_q, d_last_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [MSG_W-1:0] shift_q, shift_d;

  logic s_ready;
  logic load;
  logic beat_acc;

  // The only combinational path: a new message may be taken in the same
  // cycle the last beat of the current one is consumed.
  assign s_ready  = (state_q == ST_IDLE) | (d_valid_q & bus.d_ready & d_last_q);
  assign load     = bus.s_valid & s_ready;
  assign beat_acc = d_valid_q & bus.d_ready;

  always_comb begin
    state_d    = state_q;
    d_valid_d  = d_valid_q;
    d_last_d   = d_last_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    if (load) begin
      state_d    = ST_SEND;
      d_valid_d  = 1'b1;
      d_last_d   = (bus.s_len == '0);
      beat_cnt_d = '0;
      len_d      = bus.s_len;
      shift_d    = bus.s_data;
    end else if (beat_acc) begin
      if (d_last_q) begin
        state_d   = ST_IDLE;
        d_valid_d = 1'b0;
        d_last_d  = 1'b0;
      end else begin
        // d_last is precomputed for the next beat so it leaves a flop
        shift_d    = shift_q >> BEAT_W;
        beat_cnt_d = beat_cnt_q + 1'b1;
        d_last_d   = (beat_cnt_d == len_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      d_valid_q  <= 1'b0;
      d_last_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      d_valid_q  <= d_valid_d;
      d_last_q   <= d_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Payload registers carry no reset; d_valid qualifies them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    len_q   <= len_d;
  end

  assign bus.s_ready = s_ready;
  assign bus.d_valid = d_valid_q;
  assign bus.d_data  = shift_q[BEAT_W-1:0];
  assign bus.d_last  = d_last_q;
  assign bus.busy    = d_valid_q;

  a_num_beats: assert property (@(posedge clk)
    (NUM_BEATS >= 2) && ((NUM_BEATS & (NUM_BEATS - 1)) == 0));

  a_src_stable: assert property (@(posedge clk) disable iff (!rstn)
    (bus.s_valid && !s_ready) |=> (bus.s_valid && $stable(bus.s_data) && $stable(bus.s_len)));

endmodule
